// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around mem_arbiter.
// Handshake: iREN/dREN/dWEN are levels held until the matching hit/err pulse; the pulse cycle never grants.
interface mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ihit;
  logic              dhit;
  logic              ierr;
  logic              derr;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, dload, ihit, dhit, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, dload, ihit, dhit, ierr, derr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes an instruction-read port and a data read/write port onto one RAM,
// data first, with registered hit/err pulses and bounded retry on RAM ERROR.
module mem_arbiter #(
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_RETRY = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

  state_e            state_q, state_d;
  logic [3:0]        retry_q, retry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic [WORD_W-1:0] iload_q, iload_d;
  logic [WORD_W-1:0] dload_q, dload_d;
  logic              wr_q, wr_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic              ierr_q, ierr_d;
  logic              derr_q, derr_d;
  logic              cooldown;

  // A pulse cycle gives the requester one cycle to drop its level request.
  assign cooldown = ihit_q | dhit_q | ierr_q | derr_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    ierr_d  = 1'b0;
    derr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cooldown) begin
          if (bus.dREN | bus.dWEN) begin
            state_d = DACC;
            addr_d  = bus.daddr;
            store_d = bus.dstore;
            wr_d    = bus.dWEN;
          end else if (bus.iREN) begin
            state_d = IACC;
            addr_d  = bus.iaddr;
            wr_d    = 1'b0;
          end
        end
      end
      DACC, IACC: begin
        if (bus.ramstate == RAM_ACCESS) begin
          state_d = IDLE;
          retry_d = '0;
          if (state_q == IACC) begin
            iload_d = bus.ramload;
            ihit_d  = 1'b1;
          end else begin
            if (!wr_q) dload_d = bus.ramload;
            dhit_d = 1'b1;
          end
        end else if (bus.ramstate == RAM_ERROR) begin
          if (retry_q == RETRY_LAST) begin
            state_d = IDLE;
            retry_d = '0;
            ierr_d  = (state_q == IACC);
            derr_d  = (state_q == DACC);
          end else begin
            retry_d = retry_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      retry_q <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      ierr_q  <= 1'b0;
      derr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      ierr_q  <= ierr_d;
      derr_q  <= derr_d;
    end
  end

  // Enables depend only on state, so both are 0 in IDLE and never high together.
  assign bus.ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
  assign bus.ramWEN   = (state_q == DACC) & wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.ierr     = ierr_q;
  assign bus.derr     = derr_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions predicted by a transaction-level RAM/arbiter model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_RETRY = 4;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] dbg_state;
  logic [3:0] pulses;
  int         checks = 0;
  int         failures = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [WORD_W-1:0] exp_iload = '0;
  logic [WORD_W-1:0] exp_dload = '0;

  mem_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus();

  mem_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 CLK = ~CLK;

  assign pulses = {bus.ihit, bus.dhit, bus.ierr, bus.derr};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  function automatic logic [WORD_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin
      failures++; $display("FAIL reset_enables: got %b expected 00", {bus.ramREN, bus.ramWEN});
    end
    checks++;
    if (bus.ramaddr !== '0 || bus.ramstore !== '0) begin
      failures++; $display("FAIL reset_ram_bus: got addr=%h store=%h expected 0", bus.ramaddr, bus.ramstore);
    end
    checks++;
    if (bus.iload !== '0 || bus.dload !== '0) begin
      failures++; $display("FAIL reset_loads: got iload=%h dload=%h expected 0", bus.iload, bus.dload);
    end
    checks++;
    if (pulses !== 4'b0000 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_pulses_state: got pulses=%b state=%0d expected 0000/0", pulses, dbg_state);
    end
    RST = 1'b0;
    tick();
    checks++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00 || pulses !== 4'b0000) begin
      failures++; $display("FAIL post_reset_idle: got en=%b pulses=%b expected 00/0000", {bus.ramREN, bus.ramWEN}, pulses);
    end
  endtask

  task automatic test_ifetch();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40) begin
      failures++; $display("FAIL ifetch_enable: got ren=%b wen=%b addr=%h expected 1/0/40", bus.ramREN, bus.ramWEN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h8C220004;
    tick();
    exp_iload = 32'h8C220004;
    checks++;
    if (pulses !== 4'b1000) begin
      failures++; $display("FAIL ifetch_ihit: got pulses=%b expected 1000", pulses);
    end
    checks++;
    if (bus.iload !== exp_iload) begin
      failures++; $display("FAIL ifetch_iload: got %h expected %h", bus.iload, exp_iload);
    end
    bus.ramstate = FREE;
    bus.iREN     = 1'b0;
    tick();
    checks++;
    if (bus.ramREN !== 1'b0 || pulses !== 4'b0000) begin
      failures++; $display("FAIL ifetch_after: got ren=%b pulses=%b expected 0/0000", bus.ramREN, pulses);
    end
  endtask

  task automatic test_priority();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    tick();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h100) begin
      failures++; $display("FAIL prio_data_first: got ren=%b wen=%b addr=%h expected 1/0/100", bus.ramREN, bus.ramWEN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0BADF00D;
    tick();
    exp_dload = 32'h0BADF00D;
    checks++;
    if (pulses !== 4'b0100 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL prio_dhit: got pulses=%b dload=%h expected 0100/%h", pulses, bus.dload, exp_dload);
    end
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      failures++; $display("FAIL prio_cooldown: got ren=%b wen=%b expected 0/0", bus.ramREN, bus.ramWEN);
    end
    tick();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
      failures++; $display("FAIL prio_instr_next: got ren=%b addr=%h expected 1/40", bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h12345678;
    tick();
    exp_iload = 32'h12345678;
    checks++;
    if (pulses !== 4'b1000 || bus.iload !== exp_iload) begin
      failures++; $display("FAIL prio_ihit: got pulses=%b iload=%h expected 1000/%h", pulses, bus.iload, exp_iload);
    end
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
  endtask

  task automatic test_write_busy();
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h200;
    bus.dstore = 32'hDEADBEEF;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h200) begin
        failures++; $display("FAIL write_cycle%0d: got wen=%b ren=%b store=%h addr=%h expected 1/0/deadbeef/200",
                             c, bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
      end
      bus.dstore   = $urandom;
      bus.daddr    = $urandom;
      bus.ramstate = (c < 4) ? BUSY : ACCESS;
      bus.ramload  = $urandom;
      tick();
    end
    checks++;
    if (pulses !== 4'b0100 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL write_dhit: got pulses=%b dload=%h expected 0100/%h", pulses, bus.dload, exp_dload);
    end
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    checks++;
    if (bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin
      failures++; $display("FAIL write_after: got wen=%b ren=%b expected 0/0", bus.ramWEN, bus.ramREN);
    end
  endtask

  task automatic test_hold_through_hit();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hA5A50001;
    tick();
    exp_dload = 32'hA5A50001;
    checks++;
    if (pulses !== 4'b0100 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL hold_first_dhit: got pulses=%b dload=%h expected 0100/%h", pulses, bus.dload, exp_dload);
    end
    bus.ramstate = FREE;
    tick();
    checks++;
    if (bus.ramREN !== 1'b0) begin
      failures++; $display("FAIL hold_no_grant_in_hit: got ren=%b expected 0", bus.ramREN);
    end
    tick();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h300) begin
      failures++; $display("FAIL hold_regrant: got ren=%b addr=%h expected 1/300", bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hA5A50002;
    tick();
    exp_dload = 32'hA5A50002;
    checks++;
    if (pulses !== 4'b0100 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL hold_second_dhit: got pulses=%b dload=%h expected 0100/%h", pulses, bus.dload, exp_dload);
    end
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    tick();
    checks++;
    if (bus.ramREN !== 1'b0 || pulses !== 4'b0000) begin
      failures++; $display("FAIL hold_released: got ren=%b pulses=%b expected 0/0000", bus.ramREN, pulses);
    end
  endtask

  task automatic test_retry();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h400;
    tick();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.ramREN !== 1'b1 || pulses !== 4'b0000) begin
        failures++; $display("FAIL retry_cycle%0d: got ren=%b pulses=%b expected 1/0000", c, bus.ramREN, pulses);
      end
      bus.ramstate = ERROR;
      bus.ramload  = $urandom;
      tick();
    end
    checks++;
    if (pulses !== 4'b0001) begin
      failures++; $display("FAIL retry_derr: got pulses=%b expected 0001", pulses);
    end
    checks++;
    if (dbg_state !== 2'd0 || bus.ramREN !== 1'b0 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL retry_idle: got state=%0d ren=%b dload=%h expected 0/0/%h", dbg_state, bus.ramREN, bus.dload, exp_dload);
    end
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h404;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h404 || pulses !== 4'b0000) begin
        failures++; $display("FAIL retry2_cycle%0d: got ren=%b addr=%h pulses=%b expected 1/404/0000", c, bus.ramREN, bus.ramaddr, pulses);
      end
      bus.ramstate = (c < 2) ? ERROR : ACCESS;
      bus.ramload  = 32'h0000C0DE;
      tick();
    end
    exp_dload = 32'h0000C0DE;
    checks++;
    if (pulses !== 4'b0100 || bus.dload !== exp_dload) begin
      failures++; $display("FAIL retry2_dhit: got pulses=%b dload=%h expected 0100/%h", pulses, bus.dload, exp_dload);
    end
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h500;
    tick();
    bus.ramstate = BUSY;
    tick();
    RST          = 1'b1;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hFFFF0000;
    tick();
    exp_iload = '0;
    exp_dload = '0;
    checks++;
    if (pulses !== 4'b0000 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl: got pulses=%b ren=%b wen=%b expected 0000/0/0", pulses, bus.ramREN, bus.ramWEN);
    end
    checks++;
    if (bus.ramaddr !== '0 || bus.ramstore !== '0 || bus.iload !== '0 || bus.dload !== '0) begin
      failures++; $display("FAIL rstmid_data: got addr=%h store=%h iload=%h dload=%h expected 0",
                           bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
    RST          = 1'b0;
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
      failures++; $display("FAIL rstmid_fresh_grant: got ren=%b addr=%h expected 1/40", bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h8C220004;
    tick();
    exp_iload = 32'h8C220004;
    checks++;
    if (pulses !== 4'b1000 || bus.iload !== exp_iload) begin
      failures++; $display("FAIL rstmid_fresh_ihit: got pulses=%b iload=%h expected 1000/%h", pulses, bus.iload, exp_iload);
    end
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
  endtask

  task automatic test_random();
    int                kind, n_serv, errs, cyc, r;
    logic              side_data, wr, done, got_hit;
    logic [ADDR_W-1:0] ia, da, a;
    logic [WORD_W-1:0] ds, v;
    logic [1:0]        st;
    logic [3:0]        exp_pulse;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      ia   = ADDR_W'($urandom_range(0, 15)) << 2;
      da   = ADDR_W'($urandom_range(0, 15)) << 2;
      ds   = $urandom;
      wr   = (kind == 2);
      bus.iREN   = (kind == 0 || kind == 3);
      bus.dWEN   = wr;
      bus.dREN   = (kind == 1 || kind == 3 || (kind == 2 && $urandom_range(0, 1) == 1));
      bus.iaddr  = ia;
      bus.daddr  = da;
      bus.dstore = ds;
      n_serv = (kind == 3) ? 2 : 1;
      for (int s = 0; s < n_serv; s++) begin
        side_data = (kind != 0) && (s == 0);
        a = side_data ? da : ia;
        tick();
        errs = 0;
        cyc = 0;
        done = 1'b0;
        got_hit = 1'b0;
        while (!done) begin
          checks++;
          if (bus.ramREN !== !(side_data && wr) || bus.ramWEN !== (side_data && wr) || bus.ramaddr !== a) begin
            failures++; $display("FAIL rand_t%0d_access: got ren=%b wen=%b addr=%h expected %b/%b/%h",
                                 t, bus.ramREN, bus.ramWEN, bus.ramaddr, !(side_data && wr), side_data && wr, a);
          end
          if (side_data && wr) begin
            checks++;
            if (bus.ramstore !== ds) begin
              failures++; $display("FAIL rand_t%0d_store: got %h expected %h", t, bus.ramstore, ds);
            end
          end
          if (side_data) begin
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
          end else begin
            bus.iaddr = $urandom;
          end
          r  = $urandom_range(0, 7);
          st = (r == 0) ? FREE : (r < 3) ? BUSY : (r < 5) ? ERROR : ACCESS;
          if (cyc >= 10) st = ACCESS;
          bus.ramstate = st;
          bus.ramload  = $urandom;
          if (st == ACCESS) begin
            done = 1'b1;
            got_hit = 1'b1;
            if (side_data && wr) begin
              mem[a] = ds;
            end else begin
              v = mem_rd(a);
              bus.ramload = v;
              exp_q.push_back(v);
            end
          end else if (st == ERROR) begin
            errs++;
            if (errs == MAX_RETRY) done = 1'b1;
          end
          cyc++;
          tick();
        end
        bus.ramstate = FREE;
        exp_pulse = got_hit ? (side_data ? 4'b0100 : 4'b1000) : (side_data ? 4'b0001 : 4'b0010);
        checks++;
        if (pulses !== exp_pulse) begin
          failures++; $display("FAIL rand_t%0d_pulse: got %b expected %b", t, pulses, exp_pulse);
        end
        if (got_hit && !(side_data && wr)) begin
          v = exp_q.pop_front();
          if (side_data) exp_dload = v;
          else exp_iload = v;
        end
        checks++;
        if (bus.iload !== exp_iload || bus.dload !== exp_dload) begin
          failures++; $display("FAIL rand_t%0d_loads: got iload=%h dload=%h expected %h/%h",
                               t, bus.iload, bus.dload, exp_iload, exp_dload);
        end
        if (side_data) begin
          bus.dREN = 1'b0;
          bus.dWEN = 1'b0;
        end else begin
          bus.iREN = 1'b0;
        end
        tick();
        checks++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || pulses !== 4'b0000) begin
          failures++; $display("FAIL rand_t%0d_cooldown: got ren=%b wen=%b pulses=%b expected 0/0/0000",
                               t, bus.ramREN, bus.ramWEN, pulses);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_write_busy();
    test_hold_through_hit();
    test_retry();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
